// File: rtl/vect_pkg.sv
// Shared types and encodings for the vector instruction front-end queue.
package vect_pkg;

  localparam int unsigned Q_XLEN  = 32;
  localparam int unsigned Q_VLMAX = 32;
  localparam int unsigned Q_VLW   = $clog2(Q_VLMAX) + 1;

  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;
  localparam logic [6:0] OPC_VARITH = 7'b1010111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPFVV = 3'b001;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPFVF = 3'b101;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  // Config flavour is selected by instr[31] (vsetvli) or instr[31:30].
  localparam logic       VSETVLI_PAT  = 1'b0;
  localparam logic [1:0] VSETIVLI_PAT = 2'b11;
  localparam logic [1:0] VSETVL_PAT   = 2'b10;

  typedef enum logic [1:0] {
    CLS_ISSUE   = 2'd0,
    CLS_CFG     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } head_cls_e;

  typedef struct packed {
    logic                  vill;
    logic [Q_XLEN-10:0]    reserved;
    logic                  vma;
    logic                  vta;
    logic [2:0]            vsew;
    logic [2:0]            vlmul;
  } vtype_t;

  localparam vtype_t VTYPE_RST = '{vill: 1'b1, default: '0};

  typedef struct packed {
    logic [6:0]        opcode;
    logic [5:0]        funct6;
    logic [2:0]        funct3;
    logic [1:0]        mop;
    logic              vm;
    logic [4:0]        vs2;
    logic [4:0]        vs1;
    logic [4:0]        vd;
    logic [2:0]        width;
    logic [Q_XLEN-1:0] scalar;
    logic [Q_XLEN-1:0] stride;
    logic [Q_VLW-1:0]  vl;
  } issue_uop_t;

  function automatic head_cls_e classify(input logic [31:0] instr);
    head_cls_e cls;
    cls = CLS_ILLEGAL;
    case (instr[6:0])
      OPC_VLOAD, OPC_VSTORE: cls = CLS_ISSUE;
      OPC_VARITH: begin
        case (instr[14:12])
          F3_OPIVV, F3_OPMVV, F3_OPIVI, F3_OPIVX, F3_OPMVX: cls = CLS_ISSUE;
          F3_OPCFG: cls = (instr[31:30] == VSETVL_PAT) ? CLS_ILLEGAL : CLS_CFG;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vect_instr_queue_if.sv
// Upstream instruction bus and downstream issue/config bus of the queue.
interface vect_instr_queue_if
  import vect_pkg::*;
#(
  parameter int unsigned XLEN = Q_XLEN,
  parameter int unsigned VLW  = Q_VLW
);
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            issue_valid_o;
  logic            issue_ready_i;
  issue_uop_t      issue_uop_o;
  logic            cfg_valid_o;
  logic [VLW-1:0]  cfg_vl_o;
  logic [VLW-1:0]  vl_o;
  logic [XLEN-1:0] vtype_o;
  logic            illegal_o;
  logic            empty_o;

  modport master (
    output instr_valid_i, instr_i, rs1_data_i, rs2_data_i, issue_ready_i,
    input  instr_ready_o, issue_valid_o, issue_uop_o, cfg_valid_o, cfg_vl_o,
           vl_o, vtype_o, illegal_o, empty_o
  );

  modport slave (
    input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i, issue_ready_i,
    output instr_ready_o, issue_valid_o, issue_uop_o, cfg_valid_o, cfg_vl_o,
           vl_o, vtype_o, illegal_o, empty_o
  );
endinterface

// File: rtl/vect_sync_fifo.sv
// Count-based synchronous FIFO; read data is the registered head entry.
module vect_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/vect_instr_queue.sv
// Vector front-end queue: buffers instructions, executes vset{i}vl{i} locally,
// pre-decodes memory/arith heads into issue uops and drops illegal ones.
module vect_instr_queue
  import vect_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = Q_XLEN,
  parameter int unsigned VLMAX = Q_VLMAX
) (
  input logic               clk_i,
  input logic               rst_i,
  vect_instr_queue_if.slave bus
);
  localparam int unsigned VLW = $clog2(VLMAX) + 1;
  localparam int unsigned W   = 32 + 2 * XLEN;

  logic [W-1:0]    head;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_rs1;
  logic [XLEN-1:0] head_rs2;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  head_cls_e       cls;

  logic            issue_valid;
  logic            cfg_fire;
  logic            illegal_fire;
  logic [XLEN-1:0] avl;
  logic            keep_vl;
  logic [XLEN-1:0] new_vtype;
  logic [VLW-1:0]  new_vl;
  issue_uop_t      uop;

  logic [VLW-1:0]  vl_r;
  vtype_t          vtype_r;
  logic            cfg_valid_r;
  logic [VLW-1:0]  cfg_vl_r;
  logic            illegal_r;

  vect_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (bus.instr_valid_i),
    .wr_data ({bus.instr_i, bus.rs1_data_i, bus.rs2_data_i}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_instr = head[W-1 -: 32];
  assign head_rs1   = head[2*XLEN-1 -: XLEN];
  assign head_rs2   = head[XLEN-1:0];

  always_comb begin
    cls          = classify(head_instr);
    issue_valid  = 1'b0;
    pop          = 1'b0;
    cfg_fire     = 1'b0;
    illegal_fire = 1'b0;
    if (!fifo_empty) begin
      case (cls)
        CLS_ISSUE: begin
          // vl == 0 makes the instruction a no-op, so it is dropped quietly.
          if (vl_r != '0) begin
            issue_valid = 1'b1;
            pop         = bus.issue_ready_i;
          end else begin
            pop = 1'b1;
          end
        end
        CLS_CFG: begin
          pop      = 1'b1;
          cfg_fire = 1'b1;
        end
        default: begin
          pop          = 1'b1;
          illegal_fire = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    avl       = head_rs1;
    keep_vl   = 1'b0;
    new_vtype = '0;
    if (head_instr[31] == VSETVLI_PAT) begin
      new_vtype = XLEN'(head_instr[30:20]);
      if (head_instr[19:15] == 5'd0) begin
        if (head_instr[11:7] != 5'd0) begin
          avl = XLEN'(VLMAX);
        end else begin
          keep_vl = 1'b1;
        end
      end
    end else begin
      new_vtype = XLEN'(head_instr[29:20]);
      avl       = XLEN'(head_instr[19:15]);
    end
    if (keep_vl) begin
      new_vl = vl_r;
    end else if (avl >= XLEN'(VLMAX)) begin
      new_vl = VLW'(VLMAX);
    end else begin
      new_vl = avl[VLW-1:0];
    end
  end

  always_comb begin
    uop.opcode = head_instr[6:0];
    uop.funct6 = head_instr[31:26];
    uop.funct3 = head_instr[14:12];
    uop.mop    = head_instr[27:26];
    uop.vm     = head_instr[25];
    uop.vs2    = head_instr[24:20];
    uop.vs1    = head_instr[19:15];
    uop.vd     = head_instr[11:7];
    uop.width  = head_instr[14:12];
    uop.stride = head_rs2;
    uop.vl     = vl_r;
    if (head_instr[6:0] == OPC_VARITH && head_instr[14:12] == F3_OPIVI) begin
      uop.scalar = {{(XLEN-5){head_instr[19]}}, head_instr[19:15]};
    end else begin
      uop.scalar = head_rs1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vl_r        <= '0;
      vtype_r     <= VTYPE_RST;
      cfg_valid_r <= 1'b0;
      cfg_vl_r    <= '0;
      illegal_r   <= 1'b0;
    end else begin
      cfg_valid_r <= cfg_fire;
      illegal_r   <= illegal_fire;
      if (cfg_fire) begin
        vl_r     <= new_vl;
        vtype_r  <= vtype_t'(new_vtype);
        cfg_vl_r <= new_vl;
      end
    end
  end

  assign bus.instr_ready_o = !fifo_full;
  assign bus.empty_o       = fifo_empty;
  assign bus.issue_valid_o = issue_valid;
  assign bus.issue_uop_o   = uop;
  assign bus.cfg_valid_o   = cfg_valid_r;
  assign bus.cfg_vl_o      = cfg_vl_r;
  assign bus.vl_o          = vl_r;
  assign bus.vtype_o       = vtype_r;
  assign bus.illegal_o     = illegal_r;
endmodule

// File: tb/tb_vect_instr_queue.sv
// Directed self-checking bench for vect_instr_queue.
module tb_vect_instr_queue;
  import vect_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vect_instr_queue_if #(.XLEN(32), .VLW(6)) bus ();

  vect_instr_queue #(.DEPTH(4), .XLEN(32), .VLMAX(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] varith(input logic [5:0] f6, input logic [2:0] f3,
                                         input logic [4:0] vs2, input logic [4:0] vs1,
                                         input logic [4:0] vd);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] vsetivli(input logic [4:0] uimm, input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, 5'd1, 7'b1010111};
  endfunction

  function automatic logic [31:0] vsetvli(input logic [4:0] rs1f, input logic [4:0] rd,
                                          input logic [10:0] zimm);
    return {1'b0, zimm, rs1f, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] vle32(input logic [4:0] vd, input logic [4:0] rs1f);
    return {3'b000, 1'b0, 2'b00, 1'b1, 5'b00000, rs1f, 3'b110, vd, 7'b0000111};
  endfunction

  task automatic push(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = ins;
    bus.rs1_data_i    = a;
    bus.rs2_data_i    = b;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", bus.instr_ready_o); end
    checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b expected 1", bus.empty_o); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin failures++; $display("FAIL rst_issue_valid: got %b expected 0", bus.issue_valid_o); end
    checks++; if (bus.cfg_valid_o !== 1'b0) begin failures++; $display("FAIL rst_cfg_valid: got %b expected 0", bus.cfg_valid_o); end
    checks++; if (bus.illegal_o !== 1'b0) begin failures++; $display("FAIL rst_illegal: got %b expected 0", bus.illegal_o); end
    checks++; if (bus.vl_o !== 6'd0) begin failures++; $display("FAIL rst_vl: got %0d expected 0", bus.vl_o); end
    checks++; if (bus.vtype_o !== 32'h8000_0000) begin failures++; $display("FAIL rst_vtype: got %h expected 80000000", bus.vtype_o); end
  endtask

  task automatic test_config();
    bus.issue_ready_i = 1'b1;
    push(vsetivli(5'd20, 10'h010), 32'd0, 32'd0);
    @(negedge clk);
    checks++; if (bus.cfg_valid_o !== 1'b1) begin failures++; $display("FAIL cfg1_pulse: got %b expected 1", bus.cfg_valid_o); end
    checks++; if (bus.cfg_vl_o !== 6'd20) begin failures++; $display("FAIL cfg1_cfg_vl: got %0d expected 20", bus.cfg_vl_o); end
    checks++; if (bus.vl_o !== 6'd20) begin failures++; $display("FAIL cfg1_vl: got %0d expected 20", bus.vl_o); end
    checks++; if (bus.vtype_o !== 32'h0000_0010) begin failures++; $display("FAIL cfg1_vtype: got %h expected 00000010", bus.vtype_o); end
    push(vsetvli(5'd5, 5'd1, 11'h0d0), 32'd100, 32'd0);
    checks++; if (bus.cfg_valid_o !== 1'b0) begin failures++; $display("FAIL cfg1_single_pulse: got %b expected 0", bus.cfg_valid_o); end
    @(negedge clk);
    checks++; if (bus.cfg_valid_o !== 1'b1) begin failures++; $display("FAIL cfg2_pulse: got %b expected 1", bus.cfg_valid_o); end
    checks++; if (bus.cfg_vl_o !== 6'd32) begin failures++; $display("FAIL cfg2_cfg_vl: got %0d expected 32", bus.cfg_vl_o); end
    checks++; if (bus.vtype_o !== 32'h0000_00d0) begin failures++; $display("FAIL cfg2_vtype: got %h expected 000000d0", bus.vtype_o); end
    // rs1=x0, rd=x0: vl kept even though rs1 data is small
    push(vsetvli(5'd0, 5'd0, 11'h058), 32'd3, 32'd0);
    checks++; if (bus.cfg_valid_o !== 1'b0) begin failures++; $display("FAIL cfg2_single_pulse: got %b expected 0", bus.cfg_valid_o); end
    @(negedge clk);
    checks++; if (bus.vl_o !== 6'd32) begin failures++; $display("FAIL cfg3_keep_vl: got %0d expected 32", bus.vl_o); end
    checks++; if (bus.vtype_o !== 32'h0000_0058) begin failures++; $display("FAIL cfg3_vtype: got %h expected 00000058", bus.vtype_o); end
    push({7'b1000000, 5'd2, 5'd3, 3'b111, 5'd1, 7'b1010111}, 32'd4, 32'd0);
    @(negedge clk);
    checks++; if (bus.illegal_o !== 1'b1) begin failures++; $display("FAIL vsetvl_illegal: got %b expected 1", bus.illegal_o); end
    checks++; if (bus.cfg_valid_o !== 1'b0) begin failures++; $display("FAIL vsetvl_no_cfg: got %b expected 0", bus.cfg_valid_o); end
    checks++; if (bus.vl_o !== 6'd32) begin failures++; $display("FAIL vsetvl_vl: got %0d expected 32", bus.vl_o); end
    @(negedge clk);
  endtask

  task automatic test_varith();
    bus.issue_ready_i = 1'b0;
    push(vsetivli(5'd8, 10'h010), 32'd0, 32'd0);
    @(negedge clk);
    push(varith(6'b000000, 3'b000, 5'd2, 5'd3, 5'd1), 32'd0, 32'd0);
    checks++; if (bus.issue_valid_o !== 1'b1) begin failures++; $display("FAIL vadd_valid: got %b expected 1", bus.issue_valid_o); end
    checks++; if (bus.issue_uop_o.funct6 !== 6'b000000) begin failures++; $display("FAIL vadd_funct6: got %b expected 000000", bus.issue_uop_o.funct6); end
    checks++; if (bus.issue_uop_o.vl !== 6'd8) begin failures++; $display("FAIL vadd_vl: got %0d expected 8", bus.issue_uop_o.vl); end
    checks++; if ({bus.issue_uop_o.vs2, bus.issue_uop_o.vs1, bus.issue_uop_o.vd} !== {5'd2, 5'd3, 5'd1}) begin failures++; $display("FAIL vadd_regs: got %h expected %h", {bus.issue_uop_o.vs2, bus.issue_uop_o.vs1, bus.issue_uop_o.vd}, {5'd2, 5'd3, 5'd1}); end
    @(negedge clk);
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_uop_o.vd !== 5'd1) begin failures++; $display("FAIL vadd_hold: got valid=%b vd=%0d expected valid=1 vd=1", bus.issue_valid_o, bus.issue_uop_o.vd); end
    bus.issue_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.empty_o !== 1'b1 || bus.issue_valid_o !== 1'b0) begin failures++; $display("FAIL vadd_popped: got empty=%b valid=%b expected empty=1 valid=0", bus.empty_o, bus.issue_valid_o); end
    push(varith(6'b000000, 3'b011, 5'd2, 5'b11101, 5'd9), 32'h1234_5678, 32'd0);
    checks++; if (bus.issue_uop_o.scalar !== 32'hFFFF_FFFD) begin failures++; $display("FAIL opivi_scalar: got %h expected fffffffd", bus.issue_uop_o.scalar); end
    push(varith(6'b000010, 3'b100, 5'd2, 5'd7, 5'd9), 32'hCAFE_F00D, 32'd0);
    checks++; if (bus.issue_uop_o.scalar !== 32'hCAFE_F00D) begin failures++; $display("FAIL opivx_scalar: got %h expected cafef00d", bus.issue_uop_o.scalar); end
    checks++; if ({bus.issue_uop_o.funct6, bus.issue_uop_o.funct3} !== {6'b000010, 3'b100}) begin failures++; $display("FAIL opivx_funct: got %b expected 000010100", {bus.issue_uop_o.funct6, bus.issue_uop_o.funct3}); end
    @(negedge clk);
  endtask

  task automatic test_full();
    bus.issue_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(varith(6'b000000, 3'b000, 5'd2, 5'(i), 5'(i)), 32'd0, 32'd0);
    checks++; if (bus.instr_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", bus.instr_ready_o); end
    push(varith(6'b000000, 3'b000, 5'd2, 5'd9, 5'd9), 32'd0, 32'd0);
    checks++; if (bus.instr_ready_o !== 1'b0 || bus.issue_uop_o.vd !== 5'd1) begin failures++; $display("FAIL full_refuse: got ready=%b vd=%0d expected ready=0 vd=1", bus.instr_ready_o, bus.issue_uop_o.vd); end
    bus.issue_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_uop_o.vd !== 5'(i)) begin failures++; $display("FAIL drain_order: got valid=%b vd=%0d expected valid=1 vd=%0d", bus.issue_valid_o, bus.issue_uop_o.vd, i); end
      @(negedge clk);
    end
    checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b expected 1", bus.empty_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] seq [3];
    logic [4:0]  seen [$];
    int          ill_cnt;
    seq[0] = varith(6'b000000, 3'b000, 5'd2, 5'd3, 5'd5);
    seq[1] = varith(6'b000000, 3'b001, 5'd2, 5'd3, 5'd6);
    seq[2] = varith(6'b000000, 3'b010, 5'd2, 5'd3, 5'd7);
    ill_cnt = 0;
    bus.issue_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.issue_valid_o === 1'b1) seen.push_back(bus.issue_uop_o.vd);
      if (bus.illegal_o === 1'b1) ill_cnt++;
      bus.instr_valid_i = (c < 3);
      if (c < 3) bus.instr_i = seq[c];
      @(negedge clk);
    end
    bus.instr_valid_i = 1'b0;
    checks++; if (seen.size() !== 2) begin failures++; $display("FAIL illegal_issue_cnt: got %0d expected 2", seen.size()); end
    checks++; if (seen.size() >= 2 && (seen[0] !== 5'd5 || seen[1] !== 5'd7)) begin failures++; $display("FAIL illegal_issue_vd: got %0d,%0d expected 5,7", seen[0], seen[1]); end
    checks++; if (ill_cnt !== 1) begin failures++; $display("FAIL illegal_pulses: got %0d expected 1", ill_cnt); end
  endtask

  task automatic test_zero_vl();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.issue_ready_i = 1'b1;
    push(vle32(5'd4, 5'd10), 32'h0000_1000, 32'h0000_0040);
    checks++; if (bus.issue_valid_o !== 1'b0) begin failures++; $display("FAIL zvl_no_issue: got %b expected 0", bus.issue_valid_o); end
    @(negedge clk);
    checks++; if (bus.empty_o !== 1'b1 || bus.illegal_o !== 1'b0) begin failures++; $display("FAIL zvl_drop: got empty=%b illegal=%b expected empty=1 illegal=0", bus.empty_o, bus.illegal_o); end
    push(vsetivli(5'd4, 10'h010), 32'd0, 32'd0);
    push(vle32(5'd4, 5'd10), 32'h0000_1000, 32'h0000_0040);
    checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_uop_o.vl !== 6'd4) begin failures++; $display("FAIL vle_issue: got valid=%b vl=%0d expected valid=1 vl=4", bus.issue_valid_o, bus.issue_uop_o.vl); end
    checks++; if (bus.issue_uop_o.stride !== 32'h0000_0040 || bus.issue_uop_o.scalar !== 32'h0000_1000) begin failures++; $display("FAIL vle_operands: got stride=%h scalar=%h expected 00000040 00001000", bus.issue_uop_o.stride, bus.issue_uop_o.scalar); end
    checks++; if ({bus.issue_uop_o.opcode, bus.issue_uop_o.width} !== {7'b0000111, 3'b110}) begin failures++; $display("FAIL vle_fields: got %b expected 0000111110", {bus.issue_uop_o.opcode, bus.issue_uop_o.width}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.issue_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) push(varith(6'b000000, 3'b000, 5'd2, 5'd3, 5'(i)), 32'd0, 32'd0);
    checks++; if (bus.empty_o !== 1'b0 || bus.vl_o !== 6'd4) begin failures++; $display("FAIL pre_rst: got empty=%b vl=%0d expected empty=0 vl=4", bus.empty_o, bus.vl_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.empty_o !== 1'b1 || bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL mid_rst_flush: got empty=%b ready=%b expected 1 1", bus.empty_o, bus.instr_ready_o); end
    checks++; if (bus.vl_o !== 6'd0 || bus.vtype_o !== 32'h8000_0000) begin failures++; $display("FAIL mid_rst_cfg: got vl=%0d vtype=%h expected 0 80000000", bus.vl_o, bus.vtype_o); end
    checks++; if (bus.issue_valid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_issue: got %b expected 0", bus.issue_valid_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.instr_valid_i = 1'b0;
    bus.instr_i       = 32'd0;
    bus.rs1_data_i    = 32'd0;
    bus.rs2_data_i    = 32'd0;
    bus.issue_ready_i = 1'b0;
    test_reset();
    test_config();
    test_varith();
    test_full();
    test_illegal();
    test_zero_vl();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
